// File: rtl/out_capture.sv
// out_capture: capture engine for the CPU's toggle-handshake output port.
// Each of CHANNELS (data, ctl) pairs delivers one word per level change of
// its ctl bit. Words wait in a one-entry holding slot per channel, are merged
// by a round-robin arbiter into a shared FIFO, and leave on a valid/ready
// stream tagged with their source channel.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   out_dat      CHANNELS*DATA_W packed channel data (channel k at k*DATA_W)
//   out_ctl      per-channel toggle strobe
//   trap         CPU trap input, latched into trap_seen
//   m_valid      FIFO head valid
//   m_ready      consumer ready; pop on m_valid & m_ready
//   m_data       FIFO head word
//   m_chan       FIFO head source channel
//   ovf_cnt      saturating count of dropped words
//   trap_seen    sticky trap flag
//   drained      trap seen and no captured output left anywhere
module out_capture #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNELS*DATA_W-1:0] out_dat,
    input  logic [CHANNELS-1:0]        out_ctl,
    input  logic                       trap,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [CH_W-1:0]            m_chan,
    output logic [CNT_W-1:0]           ovf_cnt,
    output logic                       trap_seen,
    output logic                       drained
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = CH_W + DATA_W;

    logic                r_armed;
    logic [CHANNELS-1:0] r_ctl_q;
    logic [CHANNELS-1:0] r_hold_v;
    logic [DATA_W-1:0]   r_hold_d [CHANNELS];
    logic [CH_W-1:0]     r_ptr;
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic [EW-1:0]       r_mem [DEPTH];
    logic [CNT_W-1:0]    r_ovf;
    logic                r_trap_seen;
    logic                r_drained;

    logic [CHANNELS-1:0] w_tog;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_gnt_v;
    logic [CH_W-1:0]     w_gnt_idx;
    logic [3:0]          w_drop;
    logic [CNT_W:0]      w_sum;
    logic [EW-1:0]       w_head;

    assign w_tog   = r_armed ? (out_ctl ^ r_ctl_q) : '0;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = !w_empty && m_ready;
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign m_valid   = !w_empty;
    assign m_data    = w_empty ? '0 : w_head[DATA_W-1:0];
    assign m_chan    = w_empty ? '0 : w_head[EW-1:DATA_W];
    assign ovf_cnt   = r_ovf;
    assign trap_seen = r_trap_seen;
    assign drained   = r_drained;

    // Round-robin: scan from the priority pointer, first pending slot wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt_v   = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = (32'(r_ptr) + i) % CHANNELS;
            if (!w_gnt_v && !w_full && r_hold_v[idx]) begin
                w_gnt_v   = 1'b1;
                w_gnt_idx = CH_W'(idx);
            end
        end
    end

    // A toggle is lost only when its slot is occupied and not leaving this cycle.
    always_comb begin
        w_drop = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (w_tog[k] && r_hold_v[k] && !(w_gnt_v && w_gnt_idx == CH_W'(k)))
                w_drop = w_drop + 4'd1;
        end
        w_sum = {1'b0, r_ovf} + (CNT_W+1)'(w_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_ctl_q     <= '0;
            r_hold_v    <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++)
                r_hold_d[k] <= '0;
            r_ptr       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_ovf       <= '0;
            r_trap_seen <= 1'b0;
            r_drained   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_ctl_q <= out_ctl;

            // Clear on grant first; a same-cycle toggle then reloads the slot.
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (w_gnt_v && w_gnt_idx == CH_W'(k))
                    r_hold_v[k] <= 1'b0;
                if (w_tog[k] && (!r_hold_v[k] || (w_gnt_v && w_gnt_idx == CH_W'(k)))) begin
                    r_hold_v[k] <= 1'b1;
                    r_hold_d[k] <= out_dat[k*DATA_W +: DATA_W];
                end
            end

            if (w_gnt_v) begin
                r_wptr <= r_wptr + 1'b1;
                if (32'(w_gnt_idx) == CHANNELS - 1)
                    r_ptr <= '0;
                else
                    r_ptr <= w_gnt_idx + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;

            r_ovf <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

            if (trap)
                r_trap_seen <= 1'b1;
            r_drained <= r_trap_seen && (r_hold_v == '0) && w_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt_v)
            r_mem[r_wptr[AW-1:0]] <= {w_gnt_idx, r_hold_d[w_gnt_idx]};
    end

endmodule

// File: tb/tb_out_capture.sv
// Directed bench for out_capture with default parameters (8-bit data,
// 2 channels, 16-entry FIFO). Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_out_capture;

    logic        clk;
    logic        rst_n;
    logic [15:0] out_dat;
    logic [1:0]  out_ctl;
    logic        trap;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_chan;
    logic [15:0] ovf_cnt;
    logic        trap_seen;
    logic        drained;

    int checks;
    int errors;
    logic [8:0] q [$];

    out_capture #(.DATA_W(8), .CHANNELS(2), .DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .out_dat(out_dat), .out_ctl(out_ctl),
        .trap(trap), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_chan(m_chan), .ovf_cnt(ovf_cnt), .trap_seen(trap_seen),
        .drained(drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted word as {chan, data}.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready)
            q.push_back({m_chan, m_data});
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] v);
        out_dat[ch*8 +: 8] = v;
        out_ctl[ch] = ~out_ctl[ch];
    endtask

    // Reset, release, and wait out the arming edge.
    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        out_ctl = 2'b11;
        rst_n   = 1'b0;
        tick(2);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_chan !== 1'b0 || ovf_cnt !== 16'h0
            || trap_seen !== 1'b0 || drained !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got v=%b d=%h c=%b ovf=%0d ts=%b dr=%b, want all 0",
                     m_valid, m_data, m_chan, ovf_cnt, trap_seen, drained);
        end
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || ovf_cnt !== 16'h0) begin
                errors++;
                $display("FAIL arm_idle[%0d]: got v=%b ovf=%0d, want v=0 ovf=0", i, m_valid, ovf_cnt);
            end
        end
    endtask

    task automatic test_stream();
        logic [7:0] chars [2];
        chars[0] = 8'h48;
        chars[1] = 8'h69;
        m_ready = 1'b1;
        q.delete();
        tick(1);
        for (int n = 0; n < 2; n++) begin
            send(0, chars[n]);
            tick(1);
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_early[%0d]: got m_valid=%b, want 0", n, m_valid);
            end
            tick(1);
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== chars[n] || m_chan !== 1'b0) begin
                errors++;
                $display("FAIL stream_head[%0d]: got v=%b d=%h c=%b, want v=1 d=%h c=0",
                         n, m_valid, m_data, m_chan, chars[n]);
            end
            tick(2);
        end
        tick(2);
        checks++;
        if (q.size() != 2 || q[0] !== 9'h048 || q[1] !== 9'h069) begin
            errors++;
            $display("FAIL stream_order: got %0d words, want 2 words 048,069", q.size());
        end
    endtask

    task automatic test_arbiter();
        logic [8:0] exp [5];
        exp[0] = 9'h041; exp[1] = 9'h142; exp[2] = 9'h043;
        exp[3] = 9'h145; exp[4] = 9'h044;
        m_ready = 1'b1;
        do_reset();
        q.delete();
        send(0, 8'h41);
        send(1, 8'h42);
        tick(5);
        send(0, 8'h43);
        tick(4);
        send(0, 8'h44);
        send(1, 8'h45);
        tick(6);
        checks++;
        if (q.size() != 5) begin
            errors++;
            $display("FAIL arb_count: got %0d words, want 5", q.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== exp[i]) begin
                errors++;
                $display("FAIL arb_word[%0d]: got %h, want %h", i, (i < q.size()) ? q[i] : 9'h1ff, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        m_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 20; i++) begin
            send(0, 8'(8'h10 + i));
            tick(1);
        end
        tick(2);
        @(negedge clk);
        checks++;
        if (ovf_cnt !== 16'd3 || m_valid !== 1'b1 || m_data !== 8'h10) begin
            errors++;
            $display("FAIL ovf_count: got ovf=%0d v=%b d=%h, want ovf=3 v=1 d=10", ovf_cnt, m_valid, m_data);
        end
        tick(3);
        @(negedge clk);
        checks++;
        if (m_data !== 8'h10 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: got v=%b d=%h, want v=1 d=10 while stalled", m_valid, m_data);
        end
        tick(1);
        m_ready = 1'b1;
        tick(22);
        checks++;
        if (q.size() != 17) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d words, want 17", q.size());
        end
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (i >= q.size() || q[i] !== {1'b0, 8'(8'h10 + i)}) begin
                errors++;
                $display("FAIL ovf_word[%0d]: got %h, want %h", i, (i < q.size()) ? q[i] : 9'h1ff,
                         {1'b0, 8'(8'h10 + i)});
            end
        end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        do_reset();
        q.delete();
        send(0, 8'h55);
        tick(1);
        send(0, 8'hAA);
        tick(6);
        checks++;
        if (ovf_cnt !== 16'd0 || q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got ovf=%0d words=%0d, want ovf=0 words=2", ovf_cnt, q.size());
        end else begin
            checks++;
            if (q[0] !== 9'h055 || q[1] !== 9'h0AA) begin
                errors++;
                $display("FAIL b2b_words: got %h,%h, want 055,0aa", q[0], q[1]);
            end
        end
    endtask

    task automatic test_trap_and_reset();
        m_ready = 1'b0;
        do_reset();
        q.delete();
        send(0, 8'h01);
        tick(1);
        send(1, 8'h02);
        tick(1);
        send(0, 8'h03);
        tick(4);
        trap = 1'b1;
        tick(1);
        trap = 1'b0;
        @(negedge clk);
        checks++;
        if (trap_seen !== 1'b1 || drained !== 1'b0) begin
            errors++;
            $display("FAIL trap_seen: got ts=%b dr=%b, want ts=1 dr=0", trap_seen, drained);
        end
        tick(1);
        m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            @(negedge clk);
            checks++;
            if (drained !== 1'b0) begin
                errors++;
                $display("FAIL drained_early[%0d]: got %b, want 0", i, drained);
            end
        end
        tick(3);
        @(negedge clk);
        checks++;
        if (drained !== 1'b1 || m_valid !== 1'b0 || q.size() != 3) begin
            errors++;
            $display("FAIL drained_final: got dr=%b v=%b words=%0d, want dr=1 v=0 words=3",
                     drained, m_valid, q.size());
        end
        m_ready = 1'b0;
        send(1, 8'h77);
        tick(3);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h77 || m_chan !== 1'b1) begin
            errors++;
            $display("FAIL late_capture: got v=%b d=%h c=%b, want v=1 d=77 c=1", m_valid, m_data, m_chan);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_chan !== 1'b0 || ovf_cnt !== 16'h0
            || trap_seen !== 1'b0 || drained !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h c=%b ovf=%0d ts=%b dr=%b, want all 0",
                     m_valid, m_data, m_chan, ovf_cnt, trap_seen, drained);
        end
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        out_dat = '0;
        out_ctl = '0;
        trap    = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_stream();
        test_arbiter();
        test_overflow();
        test_back_to_back();
        test_trap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
